// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: register sizes,
// writeback source codes, forwarding selects and FSM states.
package hazard_ctrl_pkg;

   localparam int unsigned REG_SIZE       = 5;
   localparam int unsigned REG_SRC_LENGTH = 2;

   localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_MEM = 2'b01;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-operand forwarding compare: picks the youngest in-flight writer of the
// operand's source register, never forwarding x0.
module hazard_ctrl_fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_SIZE-1:0] rs_e_i,
   input  logic [REG_SIZE-1:0] wr_addr_m_i,
   input  logic [REG_SIZE-1:0] wr_addr_w_i,
   input  logic                we_m_i,
   input  logic                we_w_i,
   output logic [1:0]          fwd_sel_o
);

   always_comb begin
      fwd_sel_o = FWD_RF;
      if (we_m_i && (wr_addr_m_i != '0) && (wr_addr_m_i == rs_e_i)) begin
         fwd_sel_o = FWD_MEM;
      end else if (we_w_i && (wr_addr_w_i != '0) && (wr_addr_w_i == rs_e_i)) begin
         fwd_sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze FSM with timeout, branch and
// load-use stall/flush priority, EX forwarding, saturating stall counter.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_SIZE-1:0]       rs1D,
   input  logic [REG_SIZE-1:0]       rs2D,
   input  logic [REG_SIZE-1:0]       rs1E,
   input  logic [REG_SIZE-1:0]       rs2E,
   input  logic [REG_SIZE-1:0]       writeRegAddrE,
   input  logic [REG_SIZE-1:0]       writeRegAddrM,
   input  logic [REG_SIZE-1:0]       writeRegAddrW,
   input  logic                      Regfile_weE,
   input  logic                      Regfile_weM,
   input  logic                      Regfile_weW,
   input  logic [REG_SRC_LENGTH-1:0] regSrc_muxE,
   input  logic                      branch_takenE,
   input  logic                      memReqM,
   input  logic                      memAck,
   output logic                      stallF,
   output logic                      stallD,
   output logic                      stallE,
   output logic                      stallM,
   output logic                      flushD,
   output logic                      flushE,
   output logic                      flushW,
   output logic [1:0]                fwdAE,
   output logic [1:0]                fwdBE,
   output logic                      mem_err,
   output logic [CNT_WIDTH-1:0]      stall_cnt
);

   localparam int unsigned TCNT_W = $clog2(MEM_TIMEOUT);

   state_e              state_q, state_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic                mem_err_q, mem_err_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   logic                freeze;
   logic                timeout;
   logic                load_use;
   logic [1:0]          fwd_a, fwd_b;

   hazard_ctrl_fwd_unit u_fwd_a (
      .rs_e_i      (rs1E),
      .wr_addr_m_i (writeRegAddrM),
      .wr_addr_w_i (writeRegAddrW),
      .we_m_i      (Regfile_weM),
      .we_w_i      (Regfile_weW),
      .fwd_sel_o   (fwd_a)
   );

   hazard_ctrl_fwd_unit u_fwd_b (
      .rs_e_i      (rs2E),
      .wr_addr_m_i (writeRegAddrM),
      .wr_addr_w_i (writeRegAddrW),
      .we_m_i      (Regfile_weM),
      .we_w_i      (Regfile_weW),
      .fwd_sel_o   (fwd_b)
   );

   assign load_use = (regSrc_muxE == REG_SRC_MEM) && Regfile_weE &&
                     (writeRegAddrE != '0) &&
                     ((writeRegAddrE == rs1D) || (writeRegAddrE == rs2D));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         tcnt_q      <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tcnt_d      = '0;
      timeout     = 1'b0;
      freeze      = 1'b0;
      stallF      = 1'b0;
      stallD      = 1'b0;
      stallE      = 1'b0;
      stallM      = 1'b0;
      flushD      = 1'b0;
      flushE      = 1'b0;
      flushW      = 1'b0;
      fwdAE       = FWD_RF;
      fwdBE       = FWD_RF;

      case (state_q)
         ST_IDLE: begin
            freeze = memReqM && !memAck;
            if (freeze) state_d = ST_WAIT_MEM;
         end
         ST_WAIT_MEM: begin
            timeout = !memAck && (tcnt_q == TCNT_W'(MEM_TIMEOUT - 1));
            freeze  = !memAck && !timeout;
            if (memAck || timeout) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // The request cycle counts as the first wait cycle, so the freeze
      // lasts MEM_TIMEOUT-1 cycles before the abort.
      if (freeze) tcnt_d = tcnt_q + TCNT_W'(1);

      if (rst) begin
         fwdAE = fwd_a;
         fwdBE = fwd_b;
         if (freeze) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
         end else if (branch_takenE) begin
            flushD = 1'b1;
            flushE = 1'b1;
         end else if (load_use) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end

      mem_err_d   = timeout;
      stall_cnt_d = stall_cnt_q;
      if (stallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
   end

   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;

endmodule
